branch_predictor: RTL and testbench

- Fetch-side producer and consumer of the branch unit's prediction interface.
- Global-history (GAg) two-level predictor. At branch issue it supplies `prediction_begin` and `pattern_begin`.
- At branch commit it takes back `prediction_end`, `pattern_end` and `failure`, then trains the pattern history table (PHT).
- On a mispredict flush it restores the speculative global history register (GHR). It also keeps commit and mispredict performance counters.

---
 rtl/branch_predictor_pkg.sv | 27 ++
 rtl/branch_predictor_pht_ram.sv | 26 ++
 rtl/branch_predictor.sv | 89 ++++++++
 tb/tb_branch_predictor.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the GAg branch predictor and the branch unit.
package branch_predictor_pkg;

  // History length; also the PHT index width.
  localparam int BP_PATTERN_WIDTH = 8;
  // Width of the retire / mispredict performance counters.
  localparam int BP_PERF_WIDTH    = 32;

  // Two-bit saturating prediction counter; bit 1 is the taken prediction.
  typedef logic [1:0] bp_ctr_t;

  // Power-up value of every PHT entry: weakly not-taken.
  localparam bp_ctr_t CTR_INIT = 2'b01;

  // Saturating step of a counter towards the resolved direction.
  function automatic bp_ctr_t ctr_update(input bp_ctr_t ctr, input logic taken);
    bp_ctr_t res;
    res = ctr;
    if (taken) begin
      if (ctr != 2'b11) res = ctr + 2'b01;
    end else begin
      if (ctr != 2'b00) res = ctr - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_predictor_pht_ram.sv
// Pattern history table: asynchronous read, synchronous write, no reset.
// Contents are set at configuration time so the array maps to distributed RAM.
module pht_ram
  import branch_predictor_pkg::*;
#(
  parameter int      IDX_W = BP_PATTERN_WIDTH,
  parameter bp_ctr_t INIT  = CTR_INIT
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  bp_ctr_t          wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output bp_ctr_t          rdata_o
);

  bp_ctr_t mem_q [2**IDX_W] = '{default: INIT};

  // Single write port; the predictor's update register drives it.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/branch_predictor.sv
// GAg two-level branch predictor: speculative global history, forwarded PHT
// lookup at issue, two-stage PHT training at commit, and perf counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int      PATTERN_WIDTH = BP_PATTERN_WIDTH,
  parameter bp_ctr_t CTR_INIT_VAL  = CTR_INIT,
  parameter int      PERF_WIDTH    = BP_PERF_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     b_issue,
  output logic [1:0]               prediction_begin,
  output logic [PATTERN_WIDTH-1:0] pattern_begin,
  output logic                     predict_taken,
  input  logic                     commit,
  input  logic                     failure,
  input  logic [1:0]               prediction_end,
  input  logic [PATTERN_WIDTH-1:0] pattern_end,
  output logic [PERF_WIDTH-1:0]    n_commit,
  output logic [PERF_WIDTH-1:0]    n_failure
);

  // Power-up values come from the declarations; reset only restores history.
  logic [PATTERN_WIDTH-1:0] ghr_q       = '0;
  logic                     upd_valid_q = 1'b0;
  logic [PATTERN_WIDTH-1:0] upd_idx_q   = '0;
  bp_ctr_t                  upd_ctr_q   = CTR_INIT_VAL;
  logic [PERF_WIDTH-1:0]    n_commit_q  = '0;
  logic [PERF_WIDTH-1:0]    n_failure_q = '0;

  logic    outcome;
  bp_ctr_t new_ctr;
  bp_ctr_t pht_rdata;
  bp_ctr_t lookup_ctr;

  // Resolved direction and trained counter; the base is the counter seen at
  // issue, so no PHT re-read is needed on the commit path.
  assign outcome = prediction_end[1] ^ failure;
  assign new_ctr = ctr_update(prediction_end, outcome);

  pht_ram #(
    .IDX_W (PATTERN_WIDTH),
    .INIT  (CTR_INIT_VAL)
  ) u_pht (
    .clk     (clk),
    .we_i    (upd_valid_q),
    .waddr_i (upd_idx_q),
    .wdata_i (upd_ctr_q),
    .raddr_i (ghr_q),
    .rdata_o (pht_rdata)
  );

  // Lookup with forwarding that hides the two-edge PHT write latency.
  always_comb begin
    lookup_ctr = pht_rdata;
    if (commit && (pattern_end == ghr_q)) begin
      lookup_ctr = new_ctr;
    end else if (upd_valid_q && (upd_idx_q == ghr_q)) begin
      lookup_ctr = upd_ctr_q;
    end
  end

  // Speculative history: flush restores from the retiring branch, else shift
  // in the prediction of the issuing branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q <= {pattern_end[PATTERN_WIDTH-2:0], outcome};
    end else if (b_issue) begin
      ghr_q <= {ghr_q[PATTERN_WIDTH-2:0], lookup_ctr[1]};
    end
  end

  // Training pipeline and performance counters; unaffected by the flush.
  always_ff @(posedge clk) begin
    upd_valid_q <= commit;
    upd_idx_q   <= pattern_end;
    upd_ctr_q   <= new_ctr;
    n_commit_q  <= n_commit_q + {{(PERF_WIDTH-1){1'b0}}, commit};
    n_failure_q <= n_failure_q + {{(PERF_WIDTH-1){1'b0}}, commit & failure};
  end

  assign prediction_begin = lookup_ctr;
  assign pattern_begin    = ghr_q;
  assign predict_taken    = lookup_ctr[1];
  assign n_commit         = n_commit_q;
  assign n_failure        = n_failure_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// random traffic, all compared against a table-level reference model.
module tb_branch_predictor;

  localparam int PW = 4;
  localparam int FW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          b_issue = 1'b0;
  logic [1:0]    prediction_begin;
  logic [PW-1:0] pattern_begin;
  logic          predict_taken;
  logic          commit = 1'b0;
  logic          failure = 1'b0;
  logic [1:0]    prediction_end = 2'b00;
  logic [PW-1:0] pattern_end = '0;
  logic [FW-1:0] n_commit;
  logic [FW-1:0] n_failure;

  branch_predictor #(
    .PATTERN_WIDTH (PW),
    .CTR_INIT_VAL  (2'b01),
    .PERF_WIDTH    (FW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .b_issue          (b_issue),
    .prediction_begin (prediction_begin),
    .pattern_begin    (pattern_begin),
    .predict_taken    (predict_taken),
    .commit           (commit),
    .failure          (failure),
    .prediction_end   (prediction_end),
    .pattern_end      (pattern_end),
    .n_commit         (n_commit),
    .n_failure        (n_failure)
  );

  always #5 clk = ~clk;

  // Reference model: the logical table as seen by the fetch side (every
  // commit is visible immediately), plus history and counters.
  int            m_pht [2**PW];
  int            m_ghr;
  int            m_ncommit;
  int            m_nfail;

  int            errors = 0;
  int            checks = 0;

  logic [1:0]    obs_pb;
  logic [PW-1:0] obs_pat;
  logic [FW-1:0] obs_nf;
  logic [FW-1:0] nf_before;

  function automatic int sat(input int c, input int taken);
    if (taken != 0) return (c >= 3) ? 3 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs mid-cycle, advance the model at the edge,
  // then return the inputs to idle.
  task automatic step(input string tag);
    int oc, nc, exp_pb, pend;
    pend   = int'(pattern_end);
    oc     = int'(prediction_end[1] ^ failure);
    nc     = sat(int'(prediction_end), oc);
    @(negedge clk);
    exp_pb = (commit && pend == m_ghr) ? nc : m_pht[m_ghr];
    obs_pb  = prediction_begin;
    obs_pat = pattern_begin;
    obs_nf  = n_failure;
    check({tag, "_pattern"}, longint'(pattern_begin), longint'(m_ghr));
    check({tag, "_pred"}, longint'(prediction_begin), longint'(exp_pb));
    check({tag, "_taken"}, longint'(predict_taken), longint'(exp_pb / 2));
    check({tag, "_ncommit"}, longint'(n_commit), longint'(m_ncommit));
    check({tag, "_nfail"}, longint'(n_failure), longint'(m_nfail));
    $display("step %s: issue=%0b commit=%0b fail=%0b reset=%0b pend=%0d pe=%0d ghr=%0d pred=%0d",
             tag, b_issue, commit, failure, reset, pend, prediction_end, pattern_begin, prediction_begin);
    @(posedge clk);
    if (commit) begin
      m_pht[pend] = nc;
      m_ncommit   = (m_ncommit + 1) % (2**FW);
      if (failure) m_nfail = (m_nfail + 1) % (2**FW);
    end
    if (reset) m_ghr = ((pend * 2) + oc) % (2**PW);
    else if (b_issue) m_ghr = ((m_ghr * 2) + (exp_pb / 2)) % (2**PW);
    #1;
    reset = 1'b0; b_issue = 1'b0; commit = 1'b0; failure = 1'b0;
    prediction_end = 2'b00; pattern_end = '0;
  endtask

  task automatic do_commit(input int idx, input int pe, input logic fl, input logic rs, input logic is);
    commit = 1'b1; pattern_end = PW'(idx); prediction_end = 2'(pe);
    failure = fl; reset = rs; b_issue = is;
  endtask

  initial begin
    for (int i = 0; i < 2**PW; i++) m_pht[i] = 1;
    m_ghr = 0; m_ncommit = 0; m_nfail = 0;
    #1;

    // Power-up state.
    step("powerup");
    check("powerup_pb", longint'(obs_pb), 1);
    check("powerup_pat", longint'(obs_pat), 0);

    // Issues predicted not-taken leave the history at zero.
    for (int i = 0; i < 3; i++) begin
      b_issue = 1'b1;
      step("issue_nt");
    end
    step("issue_nt_after");
    check("issue_nt_ghr", longint'(obs_pat), 0);

    // Train pht[0] and pht[1] to strongly taken, then issue twice.
    do_commit(0, 3, 1'b0, 1'b0, 1'b0); step("train0");
    do_commit(1, 3, 1'b0, 1'b0, 1'b0); step("train1");
    b_issue = 1'b1; step("issue_t0");
    b_issue = 1'b1; step("issue_t1");
    step("issue_t_after");
    check("issue_t_ghr", longint'(obs_pat), 3);

    // Flush to history 0101.
    do_commit(2, 0, 1'b1, 1'b1, 1'b0); step("flush_to5");
    step("at5");
    check("flush_ghr5", longint'(obs_pat), 5);

    // Same-cycle, update-register and table forwarding of a saturated counter.
    do_commit(5, 3, 1'b0, 1'b0, 1'b0); step("fwd_commit");
    check("fwd_commit_pb", longint'(obs_pb), 3);
    step("fwd_upd");
    check("fwd_upd_pb", longint'(obs_pb), 3);
    step("fwd_pht");
    check("fwd_pht_pb", longint'(obs_pb), 3);
    nf_before = obs_nf;

    // Mispredict flush with a concurrent issue that must be ignored.
    do_commit(5, 2, 1'b1, 1'b1, 1'b1); step("mispredict");
    step("after_mp");
    check("mp_ghr", longint'(obs_pat), 10);
    check("mp_nfail", longint'(obs_nf), longint'(nf_before + 1'b1));
    do_commit(2, 0, 1'b1, 1'b1, 1'b0); step("back_to5");
    step("check_pht5");
    check("mp_pht5", longint'(obs_pb), 1);

    // Saturation at the bottom.
    do_commit(5, 0, 1'b1, 1'b0, 1'b0); step("sat_up");
    check("sat_up_pb", longint'(obs_pb), 1);
    do_commit(5, 0, 1'b0, 1'b0, 1'b0); step("sat_low");
    check("sat_low_pb", longint'(obs_pb), 0);

    // Failure without commit is not counted.
    step("idle_nf");
    nf_before = obs_nf;
    failure = 1'b1; step("fail_nocommit");
    step("after_nocommit");
    check("nocommit_nfail", longint'(obs_nf), longint'(nf_before));

    // Random traffic; long enough for the counters to wrap.
    for (int n = 0; n < 300; n++) begin
      commit         = 1'($urandom_range(0, 1));
      failure        = 1'($urandom_range(0, 1));
      reset          = commit && ($urandom_range(0, 7) == 0);
      b_issue        = 1'($urandom_range(0, 1));
      prediction_end = 2'($urandom_range(0, 3));
      pattern_end    = ($urandom_range(0, 1) == 1) ? PW'(m_ghr) : PW'($urandom_range(0, 2**PW - 1));
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
